// File: rtl/sp_memory.sv
// sp_memory: single-port synchronous RAM with byte-write strobes.
// One access per clock (read or write), registered read data, synchronous
// active-low reset that clears only rdata and suppresses any write that cycle.
//
// Ports:
//   clk    - clock, all activity on the rising edge
//   rst_n  - synchronous active-low reset
//   cs     - chip select, an access happens only when 1
//   we     - 1 = write, 0 = read (when cs = 1)
//   addr   - word address
//   wdata  - write data
//   wstrb  - byte write enables, bit i covers wdata[8i+7:8i]
//   rdata  - registered read data

// Byte-lane storage core shared by every TECHNOLOGY choice.
module sp_memory_array #(
  parameter int unsigned WIDTH = 32,
  parameter int unsigned DEPTH = 1024,
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned NB = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cs,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [NB-1:0]    wstrb,
  output logic [WIDTH-1:0] rdata
);

  logic in_range_c;
  logic wr_en_c;
  logic rd_en_c;

  // Addresses past DEPTH only exist when DEPTH is not a power of two.
  if ((32'(1) << AW) == DEPTH) begin : g_pow2
    assign in_range_c = 1'b1;
  end else begin : g_npow2
    assign in_range_c = (32'(addr) < DEPTH);
  end

  // Reset blocks the write; out-of-range writes are dropped.
  assign wr_en_c = rst_n && cs && we && in_range_c;
  assign rd_en_c = cs && !we;

  // One 8-bit array per lane so each strobe owns its storage outright.
  for (genvar i = 0; i < NB; i++) begin : g_lane
    logic [7:0] mem [DEPTH];
    logic [7:0] rd_lane;

    always_ff @(posedge clk) begin : p_write
      if (wr_en_c && wstrb[i]) begin
        mem[addr] <= wdata[8*i +: 8];
      end
    end

    // Read register: holds across idles and writes, zero on out-of-range read.
    always_ff @(posedge clk) begin : p_read
      if (!rst_n) begin
        rd_lane <= 8'h00;
      end else if (rd_en_c) begin
        rd_lane <= in_range_c ? mem[addr] : 8'h00;
      end
    end

    assign rdata[8*i +: 8] = rd_lane;
  end

endmodule

// Top: selects the storage implementation; all choices build the generic array.
module sp_memory #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned DEPTH      = 1024,
  parameter string       TECHNOLOGY = "GENERIC",
  localparam int unsigned AW = $clog2(DEPTH),
  localparam int unsigned NB = WIDTH / 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cs,
  input  logic             we,
  input  logic [AW-1:0]    addr,
  input  logic [WIDTH-1:0] wdata,
  input  logic [NB-1:0]    wstrb,
  output logic [WIDTH-1:0] rdata
);

  if (TECHNOLOGY == "GENERIC") begin : g_generic
    sp_memory_array #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_array (
      .clk   (clk),
      .rst_n (rst_n),
      .cs    (cs),
      .we    (we),
      .addr  (addr),
      .wdata (wdata),
      .wstrb (wstrb),
      .rdata (rdata)
    );
  end else begin : g_fallback
    // No technology macros are available; keep behaviour identical.
    sp_memory_array #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
    ) u_array (
      .clk   (clk),
      .rst_n (rst_n),
      .cs    (cs),
      .we    (we),
      .addr  (addr),
      .wdata (wdata),
      .wstrb (wstrb),
      .rdata (rdata)
    );
  end

endmodule

// File: tb/tb_sp_memory.sv
// Testbench for sp_memory: directed vectors with hand-computed rdata, then a
// random mix checked against a byte-lane reference model. Stimulus pushes
// the expected rdata for each applied cycle; a monitor pops and compares.
module tb_sp_memory;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned DEPTH = 1024;
  localparam int unsigned AW    = 10;
  localparam int unsigned NB    = 4;
  localparam int unsigned NPOOL = 16;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cs;
  logic             we;
  logic [AW-1:0]    addr;
  logic [WIDTH-1:0] wdata;
  logic [NB-1:0]    wstrb;
  logic [WIDTH-1:0] rdata;

  logic [WIDTH-1:0] exp_q  [$];
  string            name_q [$];
  int               vectors     = 0;
  int               miscompares = 0;

  logic [WIDTH-1:0] model [NPOOL];
  logic [WIDTH-1:0] model_rdata;

  always #5 clk = ~clk;

  sp_memory #(
    .WIDTH      (WIDTH),
    .DEPTH      (DEPTH),
    .TECHNOLOGY ("GENERIC")
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .cs    (cs),
    .we    (we),
    .addr  (addr),
    .wdata (wdata),
    .wstrb (wstrb),
    .rdata (rdata)
  );

  // Monitor: rdata is presented after every edge; compare on the falling edge.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      logic [WIDTH-1:0] e;
      string            n;
      e = exp_q.pop_front();
      n = name_q.pop_front();
      vectors++;
      if (rdata !== e) begin
        miscompares++;
        $display("FAIL %s: rdata=%h required %h", n, rdata, e);
      end
    end
  end

  // Apply one cycle of inputs and queue the rdata expected after that edge.
  task automatic apply(input logic r, input logic c, input logic w,
                       input logic [AW-1:0] a, input logic [WIDTH-1:0] d,
                       input logic [NB-1:0] s, input logic [WIDTH-1:0] e,
                       input string n);
    rst_n = r;
    cs    = c;
    we    = w;
    addr  = a;
    wdata = d;
    wstrb = s;
    @(posedge clk);
    #1;
    exp_q.push_back(e);
    name_q.push_back(n);
    model_rdata = e;
  endtask

  function automatic logic [WIDTH-1:0] merge(input logic [WIDTH-1:0] old,
                                             input logic [WIDTH-1:0] d,
                                             input logic [NB-1:0] s);
    logic [WIDTH-1:0] res;
    res = old;
    for (int i = 0; i < NB; i++) begin
      if (s[i]) res[8*i +: 8] = d[8*i +: 8];
    end
    return res;
  endfunction

  initial begin
    rst_n = 1'b0; cs = 1'b0; we = 1'b0; addr = '0; wdata = '0; wstrb = '0;
    model_rdata = '0;
    @(posedge clk);
    #1;

    // Reset then idle
    apply(0, 0, 0, 10'd0, 32'h0, 4'h0, 32'h0, "reset_a");
    apply(0, 0, 0, 10'd0, 32'h0, 4'h0, 32'h0, "reset_b");
    for (int i = 0; i < 3; i++) apply(1, 0, 0, 10'd0, 32'h0, 4'h0, 32'h0, "idle_after_reset");

    // Full-word write / read, then hold through idles
    apply(1, 1, 1, 10'd5, 32'hDEADBEEF, 4'hF, 32'h0, "write5_no_rdata_change");
    apply(1, 1, 0, 10'd5, 32'h0, 4'h0, 32'hDEADBEEF, "read5");
    for (int i = 0; i < 3; i++) apply(1, 0, 0, 10'd9, 32'h0, 4'hF, 32'hDEADBEEF, "idle_hold");

    // Byte strobes
    apply(1, 1, 1, 10'd7, 32'h11223344, 4'hF, 32'hDEADBEEF, "write7_full");
    apply(1, 1, 1, 10'd7, 32'hAABBCCDD, 4'h5, 32'hDEADBEEF, "write7_strb5");
    apply(1, 1, 0, 10'd7, 32'hFFFFFFFF, 4'hF, 32'h11BB33DD, "read7_merged");
    apply(1, 1, 1, 10'd7, 32'hFFFFFFFF, 4'h0, 32'h11BB33DD, "write7_strb0");
    apply(1, 1, 0, 10'd7, 32'h0, 4'h0, 32'h11BB33DD, "read7_after_strb0");
    apply(1, 1, 1, 10'd7, 32'h99999999, 4'hA, 32'h11BB33DD, "write7_strbA");
    apply(1, 1, 0, 10'd7, 32'h0, 4'h0, 32'h99BB99DD, "read7_strbA");

    // Boundaries and back-to-back reads
    apply(1, 1, 1, 10'd0, 32'hA5A5A5A5, 4'hF, 32'h99BB99DD, "write0");
    apply(1, 1, 1, 10'd1023, 32'h5A5A5A5A, 4'hF, 32'h99BB99DD, "write1023");
    apply(1, 1, 0, 10'd1023, 32'h0, 4'h0, 32'h5A5A5A5A, "read1023");
    apply(1, 1, 0, 10'd0, 32'h0, 4'h0, 32'hA5A5A5A5, "read0_b2b");
    apply(1, 1, 0, 10'd1023, 32'h0, 4'h0, 32'h5A5A5A5A, "read1023_again");
    apply(1, 1, 1, 10'd9, 32'h00000000, 4'hF, 32'h5A5A5A5A, "write_between_reads");
    apply(1, 1, 0, 10'd0, 32'h0, 4'h0, 32'hA5A5A5A5, "read0_after_write");
    apply(1, 1, 0, 10'd9, 32'h0, 4'h0, 32'h00000000, "read9");

    // Same-address write then read
    apply(1, 1, 1, 10'd12, 32'hCAFEF00D, 4'hF, 32'h00000000, "write12");
    apply(1, 1, 0, 10'd12, 32'h0, 4'h0, 32'hCAFEF00D, "read12_b2b");

    // Reset mid-operation: write suppressed, contents retained
    apply(1, 1, 1, 10'd3, 32'h12345678, 4'hF, 32'hCAFEF00D, "write3");
    apply(0, 1, 1, 10'd3, 32'hFFFFFFFF, 4'hF, 32'h0, "reset_with_write");
    apply(1, 0, 0, 10'd3, 32'h0, 4'h0, 32'h0, "idle_after_mid_reset");
    apply(1, 1, 0, 10'd3, 32'h0, 4'h0, 32'h12345678, "read3_retained");

    // Random regression: preload a known pool, then mix operations
    for (int i = 0; i < NPOOL; i++) begin
      logic [WIDTH-1:0] d;
      d = $urandom();
      model[i] = d;
      apply(1, 1, 1, AW'(i), d, 4'hF, model_rdata, "rand_preload");
    end
    for (int n = 0; n < 10000; n++) begin
      int unsigned      op;
      logic [AW-1:0]    a;
      logic [WIDTH-1:0] d;
      logic [NB-1:0]    s;
      op = $urandom_range(0, 99);
      a  = AW'($urandom_range(0, NPOOL - 1));
      d  = $urandom();
      s  = NB'($urandom_range(0, 15));
      if (op < 3) begin
        apply(0, 1, 1, a, d, s, 32'h0, "rand_reset");
      end else if (op < 20) begin
        apply(1, 0, 1, a, d, s, model_rdata, "rand_idle");
      end else if (op < 50) begin
        apply(1, 1, 0, a, d, s, model[a[3:0]], "rand_read");
      end else if (op < 75) begin
        model[a[3:0]] = merge(model[a[3:0]], d, s);
        apply(1, 1, 1, a, d, s, model_rdata, "rand_write");
      end else begin
        model[a[3:0]] = merge(model[a[3:0]], d, s);
        apply(1, 1, 1, a, d, s, model_rdata, "rand_pair_write");
        apply(1, 1, 0, a, ~d, ~s, model[a[3:0]], "rand_pair_read");
      end
    end

    // Drain the scoreboard with a bounded wait
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(posedge clk);
    if (exp_q.size() > 0) begin
      miscompares++;
      $display("FAIL drain: %0d entries pending, required 0", exp_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
